lis3dh_spi_responder: RTL and testbench
=======================================

Name: lis3dh_spi_responder

Overview:
Synthesizable SPI responder modelling the LIS3DH accelerometer's register interface. It is the far end of our `spi` master. It samples `cs`/`spc`/`sdi` with the system clock, decodes the 8-bit command byte, and serves single or auto-increment register reads and writes. It is used as a bench/FPGA stand-in for the sensor and exposes control registers plus injectable X/Y/Z samples.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops on cs, spc and sdi (minimum 2).
- WHO_AM_I_VAL, 8'h33, value returned at address 0x0F.
- CTRL_REG1_RST, 8'h07, reset value of CTRL_REG1 (0x20).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- cs  in  1  SPI chip select, active low (asynchronous to clk).
- spc  in  1  SPI clock, idles high (mode 3).
- sdi  in  1  master-to-responder serial data.
- sdo  out  1  responder-to-master serial data.
- sdo_oe  out  1  high while sdo is being driven (read data phase).
- accel_x / accel_y / accel_z  in  16 each  sample values, two's complement.
- sample_valid  in  1  one-cycle strobe; capture accel_* into OUT registers.
- ctrl_reg1  out  8  current CTRL_REG1 (0x20).
- ctrl_reg4  out  8  current CTRL_REG4 (0x23).
- wr_strobe  out  1  one-cycle pulse on each committed register write.
- wr_addr  out  6  address of the committed write.
- wr_data  out  8  data of the committed write.

Behaviour:
- Reset values: sdo=1, sdo_oe=0, ctrl_reg1=CTRL_REG1_RST, CTRL_REG2..6 (0x21–0x25)=0x00, OUT regs=0, wr_strobe=0, wr_addr=0, wr_data=0. FSM is in IDLE.
- Synchronization and edge detection:
  - cs, spc and sdi each pass through SYNC_STAGES flops.
  - spc rise and fall are detected from the last two synced samples.
  - spc high and low times must each be ≥4 clk; faster spc is unsupported.
- Mode 3 timing: sdi is sampled on spc rise; sdo is updated on the first clk after a detected spc fall.
- Frame format (MSB first):
  - Bit 7 = R/W (1 = read).
  - Bit 6 = MS (1 = auto-increment).
  - Bits 5:0 = address.
  - Data bytes follow.
- FSM: IDLE → CMD on synced cs falling. CMD shifts 8 bits, then:
  - Read command → RD. Load tx byte from reg[addr], set sdo_oe=1, present bit 7 on the next spc fall.
  - Write command → WR.
- RD:
  - Each spc fall shifts the next bit onto sdo.
  - After the 8th bit of a byte: if MS=1, addr=addr+1 (6-bit wrap, 0x3F→0x00); if MS=0, addr is unchanged. The next byte is then reloaded.
- WR:
  - After 8 rising-edge bits, commit the byte.
  - Writable addresses are 0x20–0x25 only; writes elsewhere are silently dropped with no wr_strobe.
  - A commit updates the register and pulses wr_strobe for 1 clk, with wr_addr/wr_data valid in that cycle.
  - Address increment follows the same MS rule as reads.
- Read map:
  - 0x0F = WHO_AM_I_VAL.
  - 0x20–0x25 = CTRL regs.
  - 0x28–0x2D = OUT_X_L, OUT_X_H, OUT_Y_L, OUT_Y_H, OUT_Z_L, OUT_Z_H.
  - All other addresses read 0x00.
- Coherence:
  - sample_valid while cs is high: OUT regs load on the next clk.
  - sample_valid while cs is low: the sample is held pending and applied the clk after synced cs rises.
  - A later strobe during the same frame overwrites the pending sample.
- Synced cs rising in any state: return to IDLE, sdo_oe=0, sdo=1.
  - A partial write byte is discarded.
  - The bit counter clears.
- cs rising in the same clk as an 8th-bit spc rise: the byte is committed before returning to IDLE.
- Asynchronous reset mid-frame restores all reset values immediately. The responder resynchronizes on the next cs falling edge.

Decomposition:
- Package lis3dh_pkg holds:
  - Address constants: ADDR_WHO_AM_I, ADDR_CTRL_REG1..6, ADDR_OUT_X_L..OUT_Z_H.
  - The state enum {IDLE, CMD, WR, RD}.
  - Command-bit positions RW_BIT=7 and MS_BIT=6.
- One sub-module, spi_sync_edge: an N-stage synchronizer with rise/fall pulse outputs, instantiated for cs and spc. sdi uses the synchronizer only.

Test Plan:
- Write frame {2'b00, 6'h20, 8'h97}: ctrl_reg1=0x97, one wr_strobe with wr_addr=0x20 and wr_data=0x97. sdo_oe stays 0 throughout.
- Read frame {2'b10, 6'h0F} with 8 dummy clocks: sdo shifts 0x33 MSB-first, sdo_oe is high only during the data byte, and sdo=1 after cs rises.
- Drive accel_x=16'h1234 with sample_valid; then read frame {2'b11, 6'h28} with 16 dummy clocks: received data = 0x34 followed by 0x12.
- Read {2'b11, 6'h3F} for 2 bytes: returns 0x00 (addr 0x3F), then wraps to 0x00 (addr 0x00). Write {2'b00, 6'h0F, 8'h55}: no wr_strobe, and a subsequent WHO_AM_I read is still 0x33.
- Write {2'b01, 6'h20, 8'hAB, 8'hCD} with cs raised after 4 bits of the second byte: ctrl_reg1=0xAB, CTRL_REG2 unchanged (0x00), exactly one wr_strobe.
- Assert sample_valid with accel_y=16'h0F0F mid-read, then read 0x2A after cs rises: the mid-frame read returns the old OUT_Y_L, the later read returns 0x0F. Assert reset mid-frame: outputs return to reset values and the next frame decodes correctly.

Source files
------------

// File: rtl/lis3dh_pkg.sv
// Shared definitions for the LIS3DH SPI responder.
// Contents:
//   - register address constants
//   - command-byte bit positions
//   - FSM state enum
//   - debug struct exported by the top
//   - a helper that tells whether an address accepts writes
package lis3dh_pkg;

  localparam logic [5:0] ADDR_WHO_AM_I  = 6'h0F;
  localparam logic [5:0] ADDR_CTRL_REG1 = 6'h20;
  localparam logic [5:0] ADDR_CTRL_REG2 = 6'h21;
  localparam logic [5:0] ADDR_CTRL_REG3 = 6'h22;
  localparam logic [5:0] ADDR_CTRL_REG4 = 6'h23;
  localparam logic [5:0] ADDR_CTRL_REG5 = 6'h24;
  localparam logic [5:0] ADDR_CTRL_REG6 = 6'h25;
  localparam logic [5:0] ADDR_OUT_X_L   = 6'h28;
  localparam logic [5:0] ADDR_OUT_X_H   = 6'h29;
  localparam logic [5:0] ADDR_OUT_Y_L   = 6'h2A;
  localparam logic [5:0] ADDR_OUT_Y_H   = 6'h2B;
  localparam logic [5:0] ADDR_OUT_Z_L   = 6'h2C;
  localparam logic [5:0] ADDR_OUT_Z_H   = 6'h2D;

  localparam int RW_BIT = 7;
  localparam int MS_BIT = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    WR   = 2'd2,
    RD   = 2'd3
  } state_t;

  // Observability bundle: FSM state plus the synchronized bus view.
  typedef struct packed {
    state_t     state;
    logic [2:0] bit_cnt;
    logic       cs_sync;
    logic       spc_sync;
  } dbg_t;

  function automatic logic is_writable(input logic [5:0] addr);
    return (addr >= ADDR_CTRL_REG1) && (addr <= ADDR_CTRL_REG6);
  endfunction

endpackage

// File: rtl/lis3dh_spi_responder_sync.sv
// N-stage synchronizer with single-cycle rise/fall pulses.
// Ports:
//   clk, reset : system clock and async active-high reset
//   d          : asynchronous input
//   q          : synchronized level
//   rise, fall : one-clk pulses on synchronized edges
// Edges are taken from the synchronized level and one extra history flop,
// so no metastable stage ever feeds the edge logic.
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_last;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync <= {STAGES{RST_VAL}};
      r_last <= RST_VAL;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], d};
      r_last <= r_sync[STAGES-1];
    end
  end

  assign q    = r_sync[STAGES-1];
  assign rise = q & ~r_last;
  assign fall = ~q & r_last;

endmodule

// File: rtl/lis3dh_spi_responder.sv
// SPI (mode 3) responder modelling the LIS3DH register interface.
// Ports:
//   clk, reset        : system clock, async active-high reset
//   cs, spc, sdi      : SPI bus from the master (asynchronous to clk)
//   sdo, sdo_oe       : read data and its output enable
//   accel_x/y/z       : injected samples
//   sample_valid      : strobe that captures accel_* into OUT registers
//   ctrl_reg1/4       : current CTRL_REG1 / CTRL_REG4
//   wr_strobe/addr/data : one-clk report of each committed write
//   dbg               : FSM state and synchronized bus view
// Frame: command byte {R/W, MS, addr[5:0]} then data bytes, MSB first.
// sdi is sampled on synced spc rise; sdo changes on the clk after a synced
// spc fall. MS=1 auto-increments the address after each data byte.
module lis3dh_spi_responder
  import lis3dh_pkg::*;
#(
  parameter int         SYNC_STAGES   = 2,
  parameter logic [7:0] WHO_AM_I_VAL  = 8'h33,
  parameter logic [7:0] CTRL_REG1_RST = 8'h07
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic        spc,
  input  logic        sdi,
  output logic        sdo,
  output logic        sdo_oe,
  input  logic [15:0] accel_x,
  input  logic [15:0] accel_y,
  input  logic [15:0] accel_z,
  input  logic        sample_valid,
  output logic [7:0]  ctrl_reg1,
  output logic [7:0]  ctrl_reg4,
  output logic        wr_strobe,
  output logic [5:0]  wr_addr,
  output logic [7:0]  wr_data,
  output dbg_t        dbg
);

  logic w_cs, w_cs_rise, w_cs_fall;
  logic w_spc, w_spc_rise, w_spc_fall;
  logic w_sdi;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
    .clk(clk), .reset(reset), .d(cs), .q(w_cs), .rise(w_cs_rise), .fall(w_cs_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_spc_sync (
    .clk(clk), .reset(reset), .d(spc), .q(w_spc), .rise(w_spc_rise), .fall(w_spc_fall)
  );

  // sdi needs the same latency as spc so data and its clock stay aligned.
  logic [SYNC_STAGES-1:0] r_sdi_sync;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_sdi_sync <= '0;
    else       r_sdi_sync <= {r_sdi_sync[SYNC_STAGES-2:0], sdi};
  end
  assign w_sdi = r_sdi_sync[SYNC_STAGES-1];

  state_t      r_state;
  logic [6:0]  r_shift;
  logic [2:0]  r_bit_cnt;
  logic        r_ms;
  logic [5:0]  r_addr;
  logic [7:0]  r_tx;
  logic        r_sdo;
  logic        r_sdo_oe;
  logic [7:0]  r_ctrl [0:5];
  logic        r_wr_strobe;
  logic [5:0]  r_wr_addr;
  logic [7:0]  r_wr_data;
  logic [15:0] r_out_x, r_out_y, r_out_z;
  logic [15:0] r_pend_x, r_pend_y, r_pend_z;
  logic        r_pend_valid;

  // Byte as it stands once the current spc rise shifts in w_sdi.
  logic [7:0] w_byte;
  logic [5:0] w_next_addr;
  logic [5:0] w_rd_addr;
  logic [7:0] w_rd_data;

  assign w_byte      = {r_shift, w_sdi};
  assign w_next_addr = r_ms ? r_addr + 6'd1 : r_addr;
  // The command byte's own address is only visible combinationally on the
  // 8th command bit, so the first read byte is fetched from w_byte.
  assign w_rd_addr   = (r_state == CMD) ? w_byte[5:0] : w_next_addr;

  always_comb begin
    w_rd_data = 8'h00;
    case (w_rd_addr)
      ADDR_WHO_AM_I:  w_rd_data = WHO_AM_I_VAL;
      ADDR_CTRL_REG1: w_rd_data = r_ctrl[0];
      ADDR_CTRL_REG2: w_rd_data = r_ctrl[1];
      ADDR_CTRL_REG3: w_rd_data = r_ctrl[2];
      ADDR_CTRL_REG4: w_rd_data = r_ctrl[3];
      ADDR_CTRL_REG5: w_rd_data = r_ctrl[4];
      ADDR_CTRL_REG6: w_rd_data = r_ctrl[5];
      ADDR_OUT_X_L:   w_rd_data = r_out_x[7:0];
      ADDR_OUT_X_H:   w_rd_data = r_out_x[15:8];
      ADDR_OUT_Y_L:   w_rd_data = r_out_y[7:0];
      ADDR_OUT_Y_H:   w_rd_data = r_out_y[15:8];
      ADDR_OUT_Z_L:   w_rd_data = r_out_z[7:0];
      ADDR_OUT_Z_H:   w_rd_data = r_out_z[15:8];
      default:        w_rd_data = 8'h00;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_shift     <= '0;
      r_bit_cnt   <= '0;
      r_ms        <= 1'b0;
      r_addr      <= '0;
      r_tx        <= '0;
      r_sdo       <= 1'b1;
      r_sdo_oe    <= 1'b0;
      r_wr_strobe <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      for (int i = 0; i < 6; i++) r_ctrl[i] <= (i == 0) ? CTRL_REG1_RST : 8'h00;
    end else begin
      r_wr_strobe <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_cs_fall) begin
            r_state   <= CMD;
            r_bit_cnt <= '0;
          end
        end
        CMD: begin
          if (w_spc_rise) begin
            r_shift   <= w_byte[6:0];
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
              r_addr <= w_byte[5:0];
              r_ms   <= w_byte[MS_BIT];
              if (w_byte[RW_BIT]) begin
                r_state  <= RD;
                r_tx     <= w_rd_data;
                r_sdo_oe <= 1'b1;
              end else begin
                r_state <= WR;
              end
            end
          end
        end
        WR: begin
          if (w_spc_rise) begin
            r_shift   <= w_byte[6:0];
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
              if (is_writable(r_addr)) begin
                r_ctrl[r_addr[2:0]] <= w_byte;
                r_wr_strobe         <= 1'b1;
                r_wr_addr           <= r_addr;
                r_wr_data           <= w_byte;
              end
              r_addr <= w_next_addr;
            end
          end
        end
        RD: begin
          if (w_spc_fall) begin
            r_sdo <= r_tx[7];
            r_tx  <= {r_tx[6:0], 1'b0};
          end
          // The master samples bit 0 on the 8th rise; reload right then so
          // the following fall already presents the next byte's MSB.
          if (w_spc_rise) begin
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
              r_addr <= w_next_addr;
              r_tx   <= w_rd_data;
            end
          end
        end
        default: r_state <= IDLE;
      endcase

      // Overrides the state update above but not a same-cycle commit.
      if (w_cs_rise) begin
        r_state   <= IDLE;
        r_sdo_oe  <= 1'b0;
        r_sdo     <= 1'b1;
        r_bit_cnt <= '0;
      end
    end
  end

  // OUT registers only change between frames so a burst read is coherent.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_x      <= '0;
      r_out_y      <= '0;
      r_out_z      <= '0;
      r_pend_x     <= '0;
      r_pend_y     <= '0;
      r_pend_z     <= '0;
      r_pend_valid <= 1'b0;
    end else if (sample_valid && w_cs) begin
      r_out_x      <= accel_x;
      r_out_y      <= accel_y;
      r_out_z      <= accel_z;
      r_pend_valid <= 1'b0;
    end else if (sample_valid) begin
      r_pend_x     <= accel_x;
      r_pend_y     <= accel_y;
      r_pend_z     <= accel_z;
      r_pend_valid <= 1'b1;
    end else if (w_cs && r_pend_valid) begin
      r_out_x      <= r_pend_x;
      r_out_y      <= r_pend_y;
      r_out_z      <= r_pend_z;
      r_pend_valid <= 1'b0;
    end
  end

  assign sdo       = r_sdo;
  assign sdo_oe    = r_sdo_oe;
  assign ctrl_reg1 = r_ctrl[0];
  assign ctrl_reg4 = r_ctrl[3];
  assign wr_strobe = r_wr_strobe;
  assign wr_addr   = r_wr_addr;
  assign wr_data   = r_wr_data;

  assign dbg.state    = r_state;
  assign dbg.bit_cnt  = r_bit_cnt;
  assign dbg.cs_sync  = w_cs;
  assign dbg.spc_sync = w_spc;

endmodule

// File: tb/tb_lis3dh_spi_responder.sv
// Directed bench for lis3dh_spi_responder: an SPI mode-3 master built from
// tasks, a write-strobe monitor, and hand-computed expected values.
module tb_lis3dh_spi_responder;
  import lis3dh_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        cs, spc, sdi;
  logic        sdo, sdo_oe;
  logic [15:0] accel_x, accel_y, accel_z;
  logic        sample_valid;
  logic [7:0]  ctrl_reg1, ctrl_reg4;
  logic        wr_strobe;
  logic [5:0]  wr_addr;
  logic [7:0]  wr_data;
  dbg_t        dbg;

  int n_checks = 0;
  int n_fail   = 0;

  // Clock / reset block
  always #5 clk = ~clk;

  lis3dh_spi_responder #(
    .SYNC_STAGES(2), .WHO_AM_I_VAL(8'h33), .CTRL_REG1_RST(8'h07)
  ) dut (
    .clk(clk), .reset(reset), .cs(cs), .spc(spc), .sdi(sdi),
    .sdo(sdo), .sdo_oe(sdo_oe),
    .accel_x(accel_x), .accel_y(accel_y), .accel_z(accel_z),
    .sample_valid(sample_valid),
    .ctrl_reg1(ctrl_reg1), .ctrl_reg4(ctrl_reg4),
    .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data),
    .dbg(dbg)
  );

  // Write-strobe monitor
  int         strobe_cnt = 0;
  logic [5:0] last_addr  = '0;
  logic [7:0] last_data  = '0;
  always @(posedge clk) begin
    if (wr_strobe === 1'b1) begin
      strobe_cnt = strobe_cnt + 1;
      last_addr  = wr_addr;
      last_data  = wr_data;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Driver tasks: inputs change on negedge, sdo is read just before spc rises.
  task automatic cs_assert();
    @(negedge clk);
    cs = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic cs_release();
    cs = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx,
                          output logic oe_all, output logic oe_any);
    rx     = 8'h00;
    oe_all = 1'b1;
    oe_any = 1'b0;
    for (int i = 7; i >= 8 - n; i--) begin
      spc = 1'b0;
      sdi = tx[i];
      repeat (6) @(negedge clk);
      rx[i]  = sdo;
      oe_all = oe_all & sdo_oe;
      oe_any = oe_any | sdo_oe;
      spc = 1'b1;
      repeat (6) @(negedge clk);
    end
  endtask

  task automatic read_reg(input logic [7:0] cmd, output logic [7:0] data);
    logic [7:0] dummy;
    logic a, b;
    cs_assert();
    spi_bits(cmd, 8, dummy, a, b);
    spi_bits(8'h00, 8, data, a, b);
    cs_release();
  endtask

  task automatic write_reg(input logic [7:0] cmd, input logic [7:0] data);
    logic [7:0] dummy;
    logic a, b;
    cs_assert();
    spi_bits(cmd, 8, dummy, a, b);
    spi_bits(data, 8, dummy, a, b);
    cs_release();
  endtask

  task automatic pulse_sample();
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    @(negedge clk);
  endtask

  logic [7:0] rx;
  logic       oe_all, oe_any;
  int         s0;

  initial begin
    reset = 1'b1; cs = 1'b1; spc = 1'b1; sdi = 1'b0;
    accel_x = '0; accel_y = '0; accel_z = '0; sample_valid = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_sdo",       32'(sdo), 32'h1);
    check("rst_sdo_oe",    32'(sdo_oe), 32'h0);
    check("rst_ctrl_reg1", 32'(ctrl_reg1), 32'h07);
    check("rst_ctrl_reg4", 32'(ctrl_reg4), 32'h00);
    check("rst_wr_strobe", 32'(wr_strobe), 32'h0);
    check("rst_wr_addr",   32'(wr_addr), 32'h0);
    check("rst_wr_data",   32'(wr_data), 32'h0);
    check("rst_state",     32'(dbg.state), 32'(IDLE));
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // Single write of 0x97 to CTRL_REG1
    s0 = strobe_cnt;
    cs_assert();
    spi_bits(8'h20, 8, rx, oe_all, oe_any);
    check("wr_cmd_oe", 32'(oe_any), 32'h0);
    spi_bits(8'h97, 8, rx, oe_all, oe_any);
    check("wr_data_oe", 32'(oe_any), 32'h0);
    cs_release();
    check("wr_ctrl_reg1",   32'(ctrl_reg1), 32'h97);
    check("wr_strobe_cnt",  32'(strobe_cnt - s0), 32'h1);
    check("wr_strobe_addr", 32'(last_addr), 32'h20);
    check("wr_strobe_data", 32'(last_data), 32'h97);

    // WHO_AM_I read
    cs_assert();
    spi_bits(8'h8F, 8, rx, oe_all, oe_any);
    check("who_cmd_oe", 32'(oe_any), 32'h0);
    spi_bits(8'h00, 8, rx, oe_all, oe_any);
    check("who_data", 32'(rx), 32'h33);
    check("who_data_oe", 32'(oe_all), 32'h1);
    cs_release();
    check("who_idle_sdo", 32'(sdo), 32'h1);
    check("who_idle_oe",  32'(sdo_oe), 32'h0);

    // Auto-increment read of OUT_X_L / OUT_X_H
    accel_x = 16'h1234;
    pulse_sample();
    cs_assert();
    spi_bits(8'hE8, 8, rx, oe_all, oe_any);
    spi_bits(8'h00, 8, rx, oe_all, oe_any);
    check("out_x_l", 32'(rx), 32'h34);
    spi_bits(8'h00, 8, rx, oe_all, oe_any);
    check("out_x_h", 32'(rx), 32'h12);
    cs_release();

    // Address wrap 0x3F -> 0x00
    cs_assert();
    spi_bits(8'hFF, 8, rx, oe_all, oe_any);
    spi_bits(8'h00, 8, rx, oe_all, oe_any);
    check("wrap_3f", 32'(rx), 32'h00);
    spi_bits(8'h00, 8, rx, oe_all, oe_any);
    check("wrap_00", 32'(rx), 32'h00);
    cs_release();

    // Write to read-only WHO_AM_I is dropped
    s0 = strobe_cnt;
    write_reg(8'h0F, 8'h55);
    check("ro_no_strobe", 32'(strobe_cnt - s0), 32'h0);
    read_reg(8'h8F, rx);
    check("ro_who_kept", 32'(rx), 32'h33);

    // Burst write aborted mid second byte
    s0 = strobe_cnt;
    cs_assert();
    spi_bits(8'h60, 8, rx, oe_all, oe_any);
    spi_bits(8'hAB, 8, rx, oe_all, oe_any);
    spi_bits(8'hCD, 4, rx, oe_all, oe_any);
    cs_release();
    check("abort_ctrl_reg1", 32'(ctrl_reg1), 32'hAB);
    check("abort_strobe_cnt", 32'(strobe_cnt - s0), 32'h1);
    check("abort_strobe_data", 32'(last_data), 32'hAB);
    read_reg(8'hA1, rx);
    check("abort_ctrl_reg2", 32'(rx), 32'h00);

    // CTRL_REG4 write and readback
    write_reg(8'h23, 8'h5A);
    check("ctrl_reg4_out", 32'(ctrl_reg4), 32'h5A);
    read_reg(8'hA3, rx);
    check("ctrl_reg4_rd", 32'(rx), 32'h5A);

    // Sample coherence across a burst read 0x29..0x2A
    accel_y = 16'hAAAA;
    pulse_sample();
    cs_assert();
    spi_bits(8'hE9, 8, rx, oe_all, oe_any);
    accel_y = 16'h0F0F;
    pulse_sample();
    accel_y = 16'hFFFF;
    spi_bits(8'h00, 8, rx, oe_all, oe_any);
    check("coh_x_h", 32'(rx), 32'h12);
    spi_bits(8'h00, 8, rx, oe_all, oe_any);
    check("coh_old_y_l", 32'(rx), 32'hAA);
    cs_release();
    read_reg(8'hAA, rx);
    check("coh_new_y_l", 32'(rx), 32'h0F);
    read_reg(8'hAB, rx);
    check("coh_new_y_h", 32'(rx), 32'h0F);

    // Reset in the middle of a read data byte
    cs_assert();
    spi_bits(8'h8F, 8, rx, oe_all, oe_any);
    spi_bits(8'h00, 3, rx, oe_all, oe_any);
    check("midrst_pre_state", 32'(dbg.state), 32'(RD));
    reset = 1'b1;
    @(negedge clk);
    check("midrst_sdo",       32'(sdo), 32'h1);
    check("midrst_sdo_oe",    32'(sdo_oe), 32'h0);
    check("midrst_ctrl_reg1", 32'(ctrl_reg1), 32'h07);
    check("midrst_ctrl_reg4", 32'(ctrl_reg4), 32'h00);
    check("midrst_state",     32'(dbg.state), 32'(IDLE));
    cs = 1'b1;
    spc = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    read_reg(8'h8F, rx);
    check("postrst_who", 32'(rx), 32'h33);
    read_reg(8'hA0, rx);
    check("postrst_ctrl_reg1", 32'(rx), 32'h07);
    read_reg(8'hA8, rx);
    check("postrst_out_x_l", 32'(rx), 32'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
